// File: rtl/note_feeder.sv
// Purpose: one lane's note supplier. Streams 16-bit note times from song memory
//          into a small prefetch FIFO and hands one note per request to the matcher.
// Latency: start -> first read next cycle -> note_available two cycles after that read.
// Backpressure: reads issue only while FIFO occupancy plus the in-flight read is
//          below DEPTH, so a returning word always has a slot.
// Ports:   clk/rst (sync, active-high); start/base_addr begin a lane;
//          mem_rd_en/mem_addr/mem_data form the 1-cycle-latency memory port;
//          note_request/note_available/note_time form the matcher handshake;
//          song_done and notes_served are status outputs.
module note_feeder #(
   parameter int          ADDR_W   = 12,
   parameter int          DEPTH    = 4,
   parameter logic [15:0] END_MARK = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_data,
   input  logic              note_request,
   output logic              note_available,
   output logic [15:0]       note_time,
   output logic              song_done,
   output logic [15:0]       notes_served
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              inflight;       // a read was issued last cycle; its data is on mem_data now
   logic              inflight_last;  // that read targeted the top address
   logic              last_issued;    // top address already read; the pointer must not wrap
   logic [15:0]       fifo [DEPTH];
   logic [PW-1:0]     rd_idx;
   logic [PW-1:0]     wr_idx;
   logic [CW-1:0]     count;
   logic              empty;
   logic              ret;
   logic              ret_end;
   logic              push;
   logic              pop;

   assign empty    = (count == '0);
   assign mem_addr = ptr;

   // start discards whatever is returning this cycle
   assign ret     = inflight && !start;
   assign push    = ret && (mem_data != END_MARK);
   assign ret_end = ret && ((mem_data == END_MARK) || inflight_last);
   // the parked all-1's word is never popped, so a pop needs real FIFO content
   assign pop     = note_request && !empty && !start;

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      if (start)
         state_nxt = FETCH;
      else if ((state == FETCH) && ret_end)
         state_nxt = DONE;
   end

   // ---- output logic ----
   always_comb begin
      mem_rd_en      = 1'b0;
      note_available = 1'b0;
      note_time      = 16'hFFFF;
      song_done      = 1'b0;
      if ((state == FETCH) && !inflight && !last_issued &&
          ((count + {{(CW-1){1'b0}}, inflight}) < DEPTH_C))
         mem_rd_en = 1'b1;
      if (!empty) begin
         note_available = 1'b1;
         note_time      = fifo[rd_idx];
      end else if (state == DONE) begin
         note_available = 1'b1;
         song_done      = 1'b1;
      end
   end

   // ---- datapath ----
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr           <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         last_issued   <= 1'b0;
         rd_idx        <= '0;
         wr_idx        <= '0;
         count         <= '0;
         notes_served  <= '0;
      end else if (start) begin
         ptr           <= base_addr;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         last_issued   <= 1'b0;
         rd_idx        <= '0;
         wr_idx        <= '0;
         count         <= '0;
         notes_served  <= '0;
      end else begin
         inflight <= mem_rd_en;
         if (mem_rd_en) begin
            inflight_last <= (ptr == '1);
            if (ptr == '1) last_issued <= 1'b1;
            else           ptr         <= ptr + ADDR_W'(1);
         end
         if (push) wr_idx <= wr_idx + PW'(1);
         if (pop) begin
            rd_idx <= rd_idx + PW'(1);
            if (notes_served != 16'hFFFF) notes_served <= notes_served + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset; occupancy tracking decides what is valid
   always_ff @(posedge clk) begin
      if (push && !rst) fifo[wr_idx] <= mem_data;
   end

endmodule
